instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Program-counter-driven fetch stage feeding the CPU decode/ALU/register-bank path. It replaces hand-stepped
//  RAM addressing: it issues reads to the instruction RAM and latches the returned 32-bit word. It then presents
//  the word to the downstream decode with a valid/ready handshake.
//  It yields the shared RAM port to memory_control (LDR/STR) on request and accepts branch redirects.
// PARAMETERS
//  ADDR_W    16            RAM address / PC width
//  DATA_W    32            instruction word width
//  RAM_LAT   1             cycles from Enable+Address to valid Ram_data (1..3)
//  RESET_PC  0             PC value loaded at reset
//  HALT_WORD 32'hFFFFFFFF  instruction encoding that halts fetch
// PORTS
//  Clk          in   1       single clock, rising edge
//  Reset        in   1       asynchronous, active-low reset
//  run          in   1       1 = fetching permitted
//  mem_busy     in   1       memory_control owns RAM this cycle; fetch must not drive Enable
//  pc_load      in   1       branch redirect strobe
//  pc_target    in   ADDR_W  redirect address
//  Ram_data     in   DATA_W  RAM read data (Out)
//  Enable       out  1       RAM enable
//  RW_ram       out  1       RAM direction; always 1 (read)
//  Address_out  out  ADDR_W  RAM address
//  instruction  out  DATA_W  latched instruction word
//  instr_pc     out  ADDR_W  address the latched instruction came from
//  instr_valid  out  1       instruction/instr_pc valid
//  instr_ready  in   1       downstream accepts when instr_valid & instr_ready
//  pc           out  ADDR_W  next fetch address
//  halted       out  1       HALT_WORD fetched; fetch stopped
// BEHAVIOUR
//  Reset (async, Reset=0)
//   - Enable=0, RW_ram=1, Address_out=RESET_PC, instruction=0, instr_pc=0
//   - instr_valid=0, pc=RESET_PC, halted=0, FSM=IDLE, latency counter=0
//  FSM states: IDLE, REQ, WAIT, HOLD
//   - IDLE: if run & !halted & !mem_busy -> REQ
//   - REQ: Enable=1, Address_out=pc; latency count=RAM_LAT; -> WAIT
//   - WAIT: Enable held 1, Address held; count down; at 0 capture Ram_data->instruction, pc->instr_pc,
//     instr_valid=1, pc<=pc+1; -> HOLD
//   - HOLD: instr_valid held, instruction stable until handshake
//     - On handshake: instr_valid<=0; next REQ in the same edge if run & !mem_busy, else IDLE
//  Timing: registered outputs; REQ cycle to instr_valid rising = RAM_LAT+1 cycles. Back-to-back throughput:
//   1 instruction per RAM_LAT+2 cycles.
//  mem_busy
//   - In REQ/WAIT: abort the fetch; Enable=0 next cycle; pc unchanged; -> IDLE; the same pc is refetched
//     after mem_busy drops.
//   - In HOLD: no effect.
//  pc_load (priority over everything except reset)
//   - Sets pc<=pc_target, instr_valid<=0, halted<=0, aborts any in-flight fetch; -> REQ if run else IDLE.
//   - With a simultaneous handshake: the word counts as consumed; pc_target is still taken.
//  Halt: captured word == HALT_WORD
//   - The word is still presented.
//   - halted<=1 at capture; no REQ afterwards until pc_load.
//  run=0: the current fetch completes and the word is held; no new REQ is issued.
//  Wrap: pc = 2^ADDR_W-1 increments to 0, no flag.
//  Enable is never 1 in the cycle after mem_busy=1 is sampled. RW_ram is never 0.
// STRUCTURE
//  Shared package cpu_pkg:
//   - ADDR_W/DATA_W defaults and HALT_WORD
//   - fetch state enum
//   - instruction field slices: Cond[31:28], OpCode[27:24], S[23], dest[22:19], src2[18:15], src1[14:11],
//     IV_ShftRor[10:6], IV_Mov[18:3]
//  Sub-module fetch_pc_reg: PC register with load/increment/wrap.
//  FSM and latency counter stay in the top module.
// TESTING
//  1. Reset low, RAM[0..2]=A,B,C, run=1, instr_ready=1, RAM_LAT=1
//     -> valid A@pc0, B@pc1, C@pc2, one every 3 cycles; pc=3.
//  2. instr_ready=0 for 5 cycles after A -> instruction stays A, instr_valid stays 1, Enable=0,
//     pc=1 throughout; B follows ready.
//  3. mem_busy=1 during WAIT of pc=1 -> Enable=0 next cycle, no capture, pc stays 1; mem_busy=0 -> refetch
//     addr 1 yields B.
//  4. pc_load=1, pc_target=16'h0040 while HOLD with A, instr_ready=1 -> A consumed; next Address_out=0x0040.
//  5. RAM[3]=32'hFFFFFFFF -> word presented, halted=1, Enable stays 0 for 20 cycles; pc_load to 0
//     -> halted=0, fetch resumes.
//  6. pc=16'hFFFF, fetch -> pc wraps to 0; assert Reset=0 mid-WAIT -> all outputs at reset values
//     asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, halt encoding, fetch states and instruction field layout
package cpu_pkg;

  localparam int          DEF_ADDR_W    = 16;
  localparam int          DEF_DATA_W    = 32;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_HOLD
  } fetch_state_e;

  // Register/ALU form: Cond[31:28] OpCode[27:24] S[23] dest[22:19] src2[18:15] src1[14:11] IV_ShftRor[10:6]
  typedef struct packed {
    logic [3:0] cond;
    logic [3:0] opcode;
    logic       s;
    logic [3:0] dest;
    logic [3:0] src2;
    logic [3:0] src1;
    logic [4:0] iv_shft_ror;
    logic [5:0] rsvd;
  } instr_alu_t;

  // Move-immediate form: IV_Mov[18:3] overlays src2/src1/IV_ShftRor
  typedef struct packed {
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        s;
    logic [3:0]  dest;
    logic [15:0] iv_mov;
    logic [2:0]  rsvd;
  } instr_mov_t;

  typedef union packed {
    instr_alu_t alu;
    instr_mov_t mov;
  } instr_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with redirect load and wrapping increment
module fetch_pc_reg #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  // Redirect beats increment; the increment wraps silently at the top of the address space.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC-driven instruction fetch with RAM sharing, redirect and halt
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                RAM_LAT   = 1,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              run,
  input  logic              mem_busy,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic [DATA_W-1:0] Ram_data,
  output logic              Enable,
  output logic              RW_ram,
  output logic [ADDR_W-1:0] Address_out,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              enable_q, enable_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc_cur;
  logic [ADDR_W-1:0] pc_next;
  logic              handshake;
  logic              can_start;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i    (Clk),
    .rst_ni   (Reset),
    .load_i   (pc_load),
    .target_i (pc_target),
    .inc_i    (pc_inc),
    .pc_o     (pc_cur)
  );

  assign pc_next   = pc_load ? pc_target : pc_cur;
  assign handshake = valid_q & instr_ready;
  assign can_start = run & ~mem_busy & ~halted_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    pc_inc     = 1'b0;

    if (pc_load) begin
      // Redirect drops whatever is in flight or held; a handshake in the same cycle still consumed it.
      valid_d  = 1'b0;
      halted_d = 1'b0;
      cnt_d    = '0;
      state_d  = (run && !mem_busy) ? FETCH_REQ : FETCH_IDLE;
    end else begin
      unique case (state_q)
        FETCH_IDLE: begin
          if (can_start) state_d = FETCH_REQ;
        end
        FETCH_REQ: begin
          if (mem_busy) begin
            state_d = FETCH_IDLE;
          end else begin
            cnt_d   = 2'(RAM_LAT);
            state_d = FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (mem_busy) begin
            cnt_d   = '0;
            state_d = FETCH_IDLE;
          end else if (cnt_q <= 2'd1) begin
            cnt_d      = '0;
            instr_d    = Ram_data;
            instr_pc_d = pc_cur;
            valid_d    = 1'b1;
            pc_inc     = 1'b1;
            if (Ram_data == HALT_WORD) halted_d = 1'b1;
            state_d    = FETCH_HOLD;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        FETCH_HOLD: begin
          if (handshake) begin
            valid_d = 1'b0;
            state_d = can_start ? FETCH_REQ : FETCH_IDLE;
          end
        end
        default: state_d = FETCH_IDLE;
      endcase
    end

    enable_d = (state_d == FETCH_REQ) || (state_d == FETCH_WAIT);
    addr_d   = (state_d == FETCH_REQ) ? pc_next : addr_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= FETCH_IDLE;
      cnt_q      <= '0;
      enable_q   <= 1'b0;
      addr_q     <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      enable_q   <= enable_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  assign Enable      = enable_q;
  assign RW_ram      = 1'b1;
  assign Address_out = addr_q;
  assign instruction = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign pc          = pc_cur;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench: directed fetch scenarios plus randomized traffic
module tb_instruction_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] W_A  = 32'h1234_5678;
  localparam logic [31:0] W_B  = 32'h9ABC_DEF0;
  localparam logic [31:0] W_C  = 32'h0BAD_F00D;
  localparam logic [31:0] W_D  = 32'h4444_0040;
  localparam logic [31:0] W_E  = 32'hE000_FFFF;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        run = 1'b0;
  logic        mem_busy = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_target = '0;
  logic [31:0] Ram_data;
  logic        Enable;
  logic        RW_ram;
  logic [15:0] Address_out;
  logic [31:0] instruction;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] pc;
  logic        halted;

  logic [31:0] ram [0:65535];
  logic [31:0] ram_q = '0;

  int n_checks = 0;
  int n_errors = 0;
  int n_caps   = 0;
  bit mon_en   = 1'b0;

  logic [15:0] exp_pc;
  logic        exp_halted;
  logic        p_valid;
  logic [31:0] p_instr;
  logic [15:0] p_ipc;

  instruction_fetch_unit dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .run         (run),
    .mem_busy    (mem_busy),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .Ram_data    (Ram_data),
    .Enable      (Enable),
    .RW_ram      (RW_ram),
    .Address_out (Address_out),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 Clk = ~Clk;

  // Single-cycle-latency RAM
  always @(posedge Clk) if (Enable) ram_q <= ram[Address_out];
  assign Ram_data = ram_q;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!instr_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    check_eq("wait_valid_timeout", instr_valid, 1);
  endtask

  task automatic next_valid(output int gap);
    int c;
    tick();
    wait_valid(c);
    gap = c + 1;
  endtask

  // Transaction-level scoreboard: every new word must be ram[expected pc]; pc follows loads and captures.
  always @(posedge Clk) begin
    #1;
    if (!mon_en) begin
      exp_pc     = '0;
      exp_halted = 1'b0;
      p_valid    = 1'b0;
      p_instr    = '0;
      p_ipc      = '0;
    end else begin
      if (pc_load) begin
        exp_pc     = pc_target;
        exp_halted = 1'b0;
        check_eq("load_drops_valid", instr_valid, 0);
      end else if (!p_valid && instr_valid) begin
        check_eq("cap_pc", instr_pc, exp_pc);
        check_eq("cap_word", instruction, ram[exp_pc]);
        if (ram[exp_pc] == HALT) exp_halted = 1'b1;
        exp_pc = exp_pc + 16'd1;
        n_caps++;
      end else if (p_valid && !instr_ready) begin
        check_eq("hold_valid", instr_valid, 1);
        check_eq("hold_word", instruction, p_instr);
        check_eq("hold_pc", instr_pc, p_ipc);
      end else if (p_valid && instr_ready) begin
        check_eq("consume_valid", instr_valid, 0);
      end
      check_eq("pc_track", pc, exp_pc);
      check_eq("halted_track", halted, exp_halted);
      check_eq("rw_read", RW_ram, 1);
      if (mem_busy) check_eq("busy_no_enable", Enable, 0);
      if (Enable) begin
        check_eq("enable_addr", Address_out, exp_pc);
        check_eq("enable_not_valid", instr_valid, 0);
      end
      if (exp_halted) check_eq("halt_no_enable", Enable, 0);
      p_valid = instr_valid;
      p_instr = instruction;
      p_ipc   = instr_pc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    logic [31:0] w;

    for (int i = 0; i < 65536; i++) begin
      w = $urandom;
      if (w == HALT) w = 32'h0;
      if ($urandom_range(31) == 0) w = HALT;
      ram[i] = w;
    end
    ram[0] = W_A; ram[1] = W_B; ram[2] = W_C;
    ram[16'h0040] = W_D; ram[16'h0041] = HALT; ram[16'hFFFF] = W_E;

    repeat (3) tick();
    check_eq("rst_enable", Enable, 0);
    check_eq("rst_rw", RW_ram, 1);
    check_eq("rst_addr", Address_out, 0);
    check_eq("rst_instr", instruction, 0);
    check_eq("rst_ipc", instr_pc, 0);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_pc", pc, 0);
    check_eq("rst_halted", halted, 0);

    // Straight-line fetch A, B, C
    Reset = 1'b1; mon_en = 1'b1; run = 1'b1; instr_ready = 1'b1;
    tick();
    check_eq("t1_req_enable", Enable, 1);
    check_eq("t1_req_addr", Address_out, 0);
    wait_valid(c);
    check_eq("t1_req_to_valid", c, 2);
    check_eq("t1_word_a", instruction, W_A);
    check_eq("t1_pc_a", instr_pc, 0);
    next_valid(c);
    check_eq("t1_gap_b", c, 3);
    check_eq("t1_word_b", instruction, W_B);
    next_valid(c);
    check_eq("t1_gap_c", c, 3);
    check_eq("t1_word_c", instruction, W_C);
    check_eq("t1_pc_after_c", pc, 3);
    run = 1'b0;
    tick(); tick();
    check_eq("t1_stop_valid", instr_valid, 0);
    check_eq("t1_stop_enable", Enable, 0);

    // Backpressure on A, then mem_busy aborts the fetch of pc 1
    pc_load = 1'b1; pc_target = 16'h0000; run = 1'b1; instr_ready = 1'b0;
    tick();
    pc_load = 1'b0;
    wait_valid(c);
    check_eq("t2_word_a", instruction, W_A);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t2_hold_valid", instr_valid, 1);
      check_eq("t2_hold_word", instruction, W_A);
      check_eq("t2_hold_enable", Enable, 0);
      check_eq("t2_hold_pc", pc, 1);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tick();
    check_eq("t3_wait_enable", Enable, 1);
    check_eq("t3_wait_addr", Address_out, 1);
    mem_busy = 1'b1;
    tick();
    check_eq("t3_abort_enable", Enable, 0);
    check_eq("t3_abort_valid", instr_valid, 0);
    check_eq("t3_abort_pc", pc, 1);
    tick();
    check_eq("t3_busy_enable", Enable, 0);
    mem_busy = 1'b0;
    wait_valid(c);
    check_eq("t3_refetch_b", instruction, W_B);
    check_eq("t3_refetch_pc", instr_pc, 1);
    mem_busy = 1'b1;
    tick(); tick();
    check_eq("t3_hold_busy_valid", instr_valid, 1);
    check_eq("t3_hold_busy_word", instruction, W_B);
    mem_busy = 1'b0;

    // Redirect with simultaneous handshake
    pc_load = 1'b1; pc_target = 16'h0040; instr_ready = 1'b1;
    tick();
    pc_load = 1'b0;
    check_eq("t4_valid_dropped", instr_valid, 0);
    check_eq("t4_pc", pc, 16'h0040);
    check_eq("t4_enable", Enable, 1);
    check_eq("t4_addr", Address_out, 16'h0040);
    wait_valid(c);
    check_eq("t4_word_d", instruction, W_D);

    // Halt word
    next_valid(c);
    check_eq("t5_halt_word", instruction, HALT);
    check_eq("t5_halt_pc", instr_pc, 16'h0041);
    check_eq("t5_halted", halted, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("t5_halt_enable", Enable, 0);
    end
    pc_load = 1'b1; pc_target = 16'h0000;
    tick();
    pc_load = 1'b0;
    check_eq("t5_unhalt", halted, 0);
    check_eq("t5_resume_enable", Enable, 1);
    wait_valid(c);
    check_eq("t5_resume_word", instruction, W_A);

    // Wrap at top of address space, then async reset mid-WAIT
    pc_load = 1'b1; pc_target = 16'hFFFF;
    tick();
    pc_load = 1'b0;
    wait_valid(c);
    check_eq("t6_word_e", instruction, W_E);
    check_eq("t6_ipc", instr_pc, 16'hFFFF);
    check_eq("t6_pc_wrap", pc, 16'h0000);
    tick();
    check_eq("t6_wrap_enable", Enable, 1);
    check_eq("t6_wrap_addr", Address_out, 16'h0000);
    @(posedge Clk);
    #2;
    mon_en = 1'b0;
    Reset = 1'b0;
    #1;
    check_eq("t6_ar_enable", Enable, 0);
    check_eq("t6_ar_rw", RW_ram, 1);
    check_eq("t6_ar_addr", Address_out, 0);
    check_eq("t6_ar_instr", instruction, 0);
    check_eq("t6_ar_ipc", instr_pc, 0);
    check_eq("t6_ar_valid", instr_valid, 0);
    check_eq("t6_ar_pc", pc, 0);
    check_eq("t6_ar_halted", halted, 0);
    tick(); tick();
    Reset = 1'b1; mon_en = 1'b1;

    // Randomized traffic under the scoreboard
    n_caps = 0;
    for (int i = 0; i < 3000; i++) begin
      run         = ($urandom_range(7) != 0);
      mem_busy    = ($urandom_range(4) == 0);
      instr_ready = $urandom_range(1);
      pc_load     = ($urandom_range(31) == 0);
      pc_target   = 16'($urandom_range(65535));
      tick();
    end
    pc_load = 1'b0;
    tick();
    check_eq("rand_progress", (n_caps > 50), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
